// File: rtl/oled_frame_arbiter.sv
// Frame-synchronous arbiter sharing one OLED pixel stream among four renderers.
// Ownership moves only on frame_begin; round-robin with minimum hold and a force override.
module oled_frame_arbiter #(
  parameter int unsigned HOLD_FRAMES = 16,
  parameter logic [15:0] BG_COLOUR   = 16'h0000,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_begin,
  input  logic [3:0]  req,
  input  logic [63:0] pix_in,
  input  logic        force_en,
  input  logic [1:0]  force_sel,
  output logic [15:0] oled_data,
  output logic [3:0]  grant,
  output logic [1:0]  active_src,
  output logic        switch_pulse
);

  typedef enum logic [1:0] {StIdle, StHold, StOpen} state_e;

  localparam logic [CNT_W-1:0] HoldMax = CNT_W'(HOLD_FRAMES);
  localparam state_e           StNew   = (HOLD_FRAMES == 0) ? StOpen : StHold;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       src_q, src_d;
  logic [3:0]       grant_q, grant_d;
  logic [15:0]      oled_data_q;
  logic             switch_pulse_q;

  logic [2:0] pick_rel, pick_idle, pick_open;
  logic       take_en, go_idle, advance;
  logic [1:0] take_idx;

  // Returns {found, index} of the first set bit searching base+1, base+2, ... base+4 (mod 4).
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int k = 4; k >= 1; k--) begin
      idx = base + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    pick_rel  = rr_pick(req, src_q);
    pick_idle = rr_pick(req, ptr_q);
    pick_open = rr_pick(req & ~grant_q, src_q);

    take_en  = 1'b0;
    take_idx = '0;
    go_idle  = 1'b0;
    advance  = 1'b0;

    if (force_en) begin
      if (state_q == StIdle || force_sel != src_q) begin
        take_en  = 1'b1;
        take_idx = force_sel;
      end else begin
        advance = 1'b1;
      end
    end else if (state_q != StIdle && !req[src_q]) begin
      take_en  = pick_rel[2];
      take_idx = pick_rel[1:0];
      go_idle  = !pick_rel[2];
    end else begin
      unique case (state_q)
        StIdle: begin
          take_en  = pick_idle[2];
          take_idx = pick_idle[1:0];
        end
        StHold: advance = 1'b1;
        StOpen: begin
          take_en  = pick_open[2];
          take_idx = pick_open[1:0];
        end
        default: go_idle = 1'b1;
      endcase
    end

    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    src_d   = src_q;
    grant_d = grant_q;

    if (frame_begin) begin
      if (take_en) begin
        state_d = StNew;
        cnt_d   = '0;
        ptr_d   = take_idx;
        src_d   = take_idx;
        grant_d = 4'b0001 << take_idx;
      end else if (go_idle) begin
        state_d = StIdle;
        cnt_d   = '0;
        src_d   = '0;
        grant_d = '0;
      end else if (advance) begin
        cnt_d = cnt_inc;
        if (state_q == StHold && cnt_inc >= HoldMax) state_d = StOpen;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      ptr_q          <= 2'd3;
      src_q          <= '0;
      grant_q        <= '0;
      oled_data_q    <= BG_COLOUR;
      switch_pulse_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      ptr_q          <= ptr_d;
      src_q          <= src_d;
      grant_q        <= grant_d;
      oled_data_q    <= (state_q == StIdle) ? BG_COLOUR : pix_in[16*src_q +: 16];
      switch_pulse_q <= frame_begin && (grant_d != grant_q);
    end
  end

  assign oled_data    = oled_data_q;
  assign grant        = grant_q;
  assign active_src   = src_q;
  assign switch_pulse = switch_pulse_q;

endmodule

// File: tb/tb_oled_frame_arbiter.sv
// Directed bench for oled_frame_arbiter (HOLD_FRAMES=2) with an expectation queue
// popped one cycle after each stimulus step.
module tb_oled_frame_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_begin;
  logic [3:0]  req;
  logic [63:0] pix_in;
  logic        force_en;
  logic [1:0]  force_sel;
  logic [15:0] oled_data;
  logic [3:0]  grant;
  logic [1:0]  active_src;
  logic        switch_pulse;

  oled_frame_arbiter #(
    .HOLD_FRAMES(2),
    .BG_COLOUR  (16'h0000),
    .CNT_W      (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_begin (frame_begin),
    .req         (req),
    .pix_in      (pix_in),
    .force_en    (force_en),
    .force_sel   (force_sel),
    .oled_data   (oled_data),
    .grant       (grant),
    .active_src  (active_src),
    .switch_pulse(switch_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [3:0]  g;
    logic [1:0]  s;
    logic        p;
    logic [15:0] d;
  } exp_t;

  exp_t        sb[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  logic [3:0]  prev_g = 4'b0000;
  logic [15:0] pix [4] = '{16'h001F, 16'hF800, 16'h07E0, 16'hFFFF};

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic check_all();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_chk++;
      assert (grant === e.g) n_pass++;
      else $error("FAIL %s grant: got %b want %b", e.tag, grant, e.g);
      n_chk++;
      assert (active_src === e.s) n_pass++;
      else $error("FAIL %s active_src: got %0d want %0d", e.tag, active_src, e.s);
      n_chk++;
      assert (switch_pulse === e.p) n_pass++;
      else $error("FAIL %s switch_pulse: got %b want %b", e.tag, switch_pulse, e.p);
      n_chk++;
      assert (oled_data === e.d) n_pass++;
      else $error("FAIL %s oled_data: got %h want %h", e.tag, oled_data, e.d);
    end
  endtask

  // Drive one cycle; exp_g is the grant expected after the coming edge.
  task automatic step(input string tag, input logic fb, input logic [3:0] exp_g);
    exp_t e;
    frame_begin = fb;
    e.tag = tag;
    e.g   = exp_g;
    e.s   = idx_of(exp_g);
    e.p   = !reset && (exp_g != prev_g);
    e.d   = (reset || prev_g == 4'b0000) ? 16'h0000 : pix[idx_of(prev_g)];
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_all();
    prev_g      = exp_g;
    frame_begin = 1'b0;
  endtask

  task automatic frame(input string tag, input logic [3:0] exp_g);
    step(tag, 1'b1, exp_g);
    step(tag, 1'b0, exp_g);
    step(tag, 1'b0, exp_g);
  endtask

  logic [3:0] rot [10] = '{4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h8, 4'h8, 4'h8, 4'h1};

  initial begin
    reset       = 1'b1;
    frame_begin = 1'b0;
    req         = 4'b1111;
    force_en    = 1'b0;
    force_sel   = 2'd0;
    pix_in      = {pix[3], pix[2], pix[1], pix[0]};
    #2;

    step("reset0", 1'b1, 4'b0000);
    step("reset1", 1'b0, 4'b0000);
    step("reset2", 1'b1, 4'b0000);
    reset = 1'b0;

    req = 4'b0010;
    step("single_idle", 1'b0, 4'b0000);
    step("single_grant", 1'b1, 4'b0010);
    step("single_pix", 1'b0, 4'b0010);
    frame("single_hold1", 4'b0010);
    frame("single_open", 4'b0010);
    frame("single_keep", 4'b0010);

    reset = 1'b1;
    req   = 4'b1011;
    step("rot_reset", 1'b0, 4'b0000);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) frame($sformatf("rot_f%0d", i), rot[i]);

    frame("rel_f11", 4'b0001);
    frame("rel_f12", 4'b0001);
    frame("rel_grant1", 4'b0010);
    req = 4'b1001;
    step("rel_midframe", 1'b0, 4'b0010);
    step("rel_to3", 1'b1, 4'b1000);
    req = 4'b0000;
    step("rel_idle_wait", 1'b0, 4'b1000);
    step("rel_to_idle", 1'b1, 4'b0000);
    step("rel_bg", 1'b0, 4'b0000);

    req = 4'b0001;
    frame("force_own0", 4'b0001);
    force_en  = 1'b1;
    force_sel = 2'd2;
    step("force_wait", 1'b0, 4'b0001);
    frame("force_grant2", 4'b0100);
    frame("force_hold", 4'b0100);
    force_en = 1'b0;
    frame("force_release", 4'b0001);

    req = 4'b1000;
    frame("mid_own3", 4'b1000);
    reset = 1'b1;
    step("mid_reset", 1'b1, 4'b0000);
    reset = 1'b0;
    req   = 4'b1111;
    step("mid_idle", 1'b0, 4'b0000);
    frame("mid_restart0", 4'b0001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
